// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter: merges branch resolutions from two decode lanes (lane 0 older)
// into an in-order update queue. The queue drains into the single write port of the
// global branch predictor. On an accepted mispredict the block pulses clrbp with the
// corrected redirect pc, then ignores lane inputs for FLUSH_CYC cycles.
// Optional feature macro: BPARB_STATS_EN (saturating update/mispredict counters).
module bp_update_arbiter #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        res0_valid,
    input  logic [31:0] res0_pc,
    input  logic [31:0] res0_target,
    input  logic        res0_taken,
    input  logic        res0_mispred,
    input  logic        res1_valid,
    input  logic [31:0] res1_pc,
    input  logic [31:0] res1_target,
    input  logic        res1_taken,
    input  logic        res1_mispred,
    output logic        stall,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic        clrbp,
    output logic [31:0] redirectpc,
    output logic [15:0] stat_upd,
    output logic [15:0] stat_mis
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } entry_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        last_q, last_d;
    logic          clrbp_q, clrbp_d;
    logic [31:0]   redir_q, redir_d;

    logic          acc0, acc1, mis0, mis1, mis_acc, deq;
    logic [AW-1:0] wr1_ptr;
    logic [CW-1:0] n_enq;
    entry_t        ent0, ent1, head, mis_ent;

    assign ent0    = '{pc: res0_pc, target: res0_target, taken: res0_taken};
    assign ent1    = '{pc: res1_pc, target: res1_target, taken: res1_taken};
    assign head    = mem_q[rd_ptr_q];

    assign stall     = (count_q >= CW'(DEPTH - 1));
    assign upd_valid = (count_q != '0);
    assign deq       = upd_valid & upd_ready;

    // A lane 0 mispredict makes lane 1 wrong-path, so it is squashed in the same cycle.
    assign acc0    = res0_valid & ~stall & (state_q == RUN);
    assign acc1    = res1_valid & ~stall & (state_q == RUN) & ~(acc0 & res0_mispred);
    assign mis0    = acc0 & res0_mispred;
    assign mis1    = acc1 & res1_mispred;
    assign mis_acc = mis0 | mis1;
    assign mis_ent = mis0 ? ent0 : ent1;

    assign n_enq   = CW'(acc0) + CW'(acc1);
    assign wr1_ptr = wr_ptr_q + AW'(acc0);

    // Empty queue shows the last dequeued entry rather than a stale storage slot.
    assign upd_pc     = upd_valid ? head.pc     : last_q.pc;
    assign upd_target = upd_valid ? head.target : last_q.target;
    assign upd_taken  = upd_valid ? head.taken  : last_q.taken;
    assign clrbp      = clrbp_q;
    assign redirectpc = redir_q;

    // Next-state for FSM, queue pointers, count, and redirect pulse.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rd_ptr_d = rd_ptr_q + AW'(deq);
        wr_ptr_d = wr_ptr_q + AW'(n_enq);
        count_d  = count_q + n_enq - CW'(deq);
        last_d   = deq ? head : last_q;
        clrbp_d  = mis_acc;
        redir_d  = '0;
        if (mis_acc) begin
            redir_d = mis_ent.taken ? mis_ent.target : mis_ent.pc + 32'd4;
        end
        case (state_q)
            RUN: begin
                if (mis_acc) begin
                    state_d = FLUSH;
                    timer_d = TW'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (timer_q == '0) begin
                    state_d = RUN;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            timer_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            clrbp_q  <= 1'b0;
            redir_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            clrbp_q  <= clrbp_d;
            redir_q  <= redir_d;
        end
    end

    // Queue storage: lane 0 lands at the write pointer, lane 1 right behind it.
    always_ff @(posedge clk) begin
        if (acc0) mem_q[wr_ptr_q] <= ent0;
        if (acc1) mem_q[wr1_ptr]  <= ent1;
    end

`ifdef BPARB_STATS_EN
    logic [15:0] stat_upd_q, stat_mis_q;

    // Saturating counters of retired updates and accepted mispredicts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (deq && stat_upd_q != '1)     stat_upd_q <= stat_upd_q + 16'd1;
            if (mis_acc && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 16'd1;
        end
    end

    assign stat_upd = stat_upd_q;
    assign stat_mis = stat_mis_q;
`else
    assign stat_upd = '0;
    assign stat_mis = '0;
`endif

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Testbench for bp_update_arbiter: table-driven per-cycle vectors with a scoreboard
// queue of expected predictor updates, plus hand-written reset and wrap sequences.
module tb_bp_update_arbiter;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [31:0] pc0, tg0;
        logic        tk0, mp0;
        logic        v1;
        logic [31:0] pc1, tg1;
        logic        tk1, mp1;
        logic        rdy;
        logic        exp_stall;
        logic        acc0, acc1;
        logic        exp_clr;
        logic [31:0] exp_redir;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res0_valid = 0, res0_taken = 0, res0_mispred = 0;
    logic [31:0] res0_pc = '0, res0_target = '0;
    logic        res1_valid = 0, res1_taken = 0, res1_mispred = 0;
    logic [31:0] res1_pc = '0, res1_target = '0;
    logic        upd_ready = 0;

    logic        stall, upd_valid, upd_taken, clrbp;
    logic [31:0] upd_pc, upd_target, redirectpc;
    logic [15:0] stat_upd, stat_mis;

    logic        stall8, upd_valid8, upd_taken8, clrbp8;
    logic [31:0] upd_pc8, upd_target8, redirectpc8;
    logic [15:0] stat_upd8, stat_mis8;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_upd  = 0;
    int   exp_mis  = 0;
    ent_t sbq[$];
    ent_t sb8[$];
    vec_t pre[2];
    vec_t tbl[22];

    always #5 clk = ~clk;

    bp_update_arbiter #(.DEPTH(4), .FLUSH_CYC(2)) dut (
        .clk(clk), .reset(reset),
        .res0_valid(res0_valid), .res0_pc(res0_pc), .res0_target(res0_target),
        .res0_taken(res0_taken), .res0_mispred(res0_mispred),
        .res1_valid(res1_valid), .res1_pc(res1_pc), .res1_target(res1_target),
        .res1_taken(res1_taken), .res1_mispred(res1_mispred),
        .stall(stall), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .clrbp(clrbp), .redirectpc(redirectpc),
        .stat_upd(stat_upd), .stat_mis(stat_mis)
    );

    bp_update_arbiter #(.DEPTH(8), .FLUSH_CYC(2)) dut8 (
        .clk(clk), .reset(reset),
        .res0_valid(res0_valid), .res0_pc(res0_pc), .res0_target(res0_target),
        .res0_taken(res0_taken), .res0_mispred(res0_mispred),
        .res1_valid(res1_valid), .res1_pc(res1_pc), .res1_target(res1_target),
        .res1_taken(res1_taken), .res1_mispred(res1_mispred),
        .stall(stall8), .upd_valid(upd_valid8), .upd_ready(upd_ready),
        .upd_pc(upd_pc8), .upd_target(upd_target8), .upd_taken(upd_taken8),
        .clrbp(clrbp8), .redirectpc(redirectpc8),
        .stat_upd(stat_upd8), .stat_mis(stat_mis8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v0, input logic [31:0] pc0, input logic [31:0] tg0,
        input logic tk0, input logic mp0,
        input logic v1, input logic [31:0] pc1, input logic [31:0] tg1,
        input logic tk1, input logic mp1,
        input logic rdy, input logic st, input logic a0, input logic a1,
        input logic clr, input logic [31:0] rd);
        vec_t v;
        v.v0 = v0; v.pc0 = pc0; v.tg0 = tg0; v.tk0 = tk0; v.mp0 = mp0;
        v.v1 = v1; v.pc1 = pc1; v.tg1 = tg1; v.tk1 = tk1; v.mp1 = mp1;
        v.rdy = rdy; v.exp_stall = st; v.acc0 = a0; v.acc1 = a1;
        v.exp_clr = clr; v.exp_redir = rd;
        return v;
    endfunction

    task automatic drive_idle();
        res0_valid = 0; res0_pc = '0; res0_target = '0; res0_taken = 0; res0_mispred = 0;
        res1_valid = 0; res1_pc = '0; res1_target = '0; res1_taken = 0; res1_mispred = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        ent_t e;
        @(negedge clk);
        res0_valid = v.v0; res0_pc = v.pc0; res0_target = v.tg0;
        res0_taken = v.tk0; res0_mispred = v.mp0;
        res1_valid = v.v1; res1_pc = v.pc1; res1_target = v.tg1;
        res1_taken = v.tk1; res1_mispred = v.mp1;
        upd_ready  = v.rdy;
        #1;
        chk({tag, " stall"}, 32'(stall), 32'(v.exp_stall));
        chk({tag, " upd_valid"}, 32'(upd_valid), 32'(sbq.size() != 0));
        if (sbq.size() != 0 && v.rdy) begin
            e = sbq.pop_front();
            exp_upd++;
            chk({tag, " upd_pc"}, upd_pc, e.pc);
            chk({tag, " upd_target"}, upd_target, e.tg);
            chk({tag, " upd_taken"}, 32'(upd_taken), 32'(e.tk));
        end
        if (v.acc0) begin
            sbq.push_back('{pc: v.pc0, tg: v.tg0, tk: v.tk0});
            if (v.mp0) exp_mis++;
        end
        if (v.acc1) begin
            sbq.push_back('{pc: v.pc1, tg: v.tg1, tk: v.tk1});
            if (v.mp1) exp_mis++;
        end
        @(posedge clk);
        #1;
        chk({tag, " clrbp"}, 32'(clrbp), 32'(v.exp_clr));
        chk({tag, " redirectpc"}, redirectpc, v.exp_redir);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive_idle();
        upd_ready = 0;
        reset = 1;
        @(posedge clk);
        #1;
        chk({tag, " upd_valid"}, 32'(upd_valid), 32'd0);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " clrbp"}, 32'(clrbp), 32'd0);
        chk({tag, " redirectpc"}, redirectpc, 32'd0);
        @(negedge clk);
        reset = 0;
        sbq.delete();
        sb8.delete();
        exp_upd = 0;
        exp_mis = 0;
    endtask

    initial begin
        ent_t e;

        // Fill three entries (last one a mispredict), then reset mid-drain/mid-flush.
        pre[0] = mk(1, 32'h10, 32'h20, 0, 0,  1, 32'h14, 32'h24, 1, 0,  0, 0, 1, 1, 0, 32'h0);
        pre[1] = mk(1, 32'h18, 32'h1C0, 1, 1, 0, 32'h0, 32'h0, 0, 0,    0, 0, 1, 0, 1, 32'h1C0);

        tbl[0]  = mk(1, 32'h3, 32'h50, 1, 0,    0, 32'h0, 32'h0, 0, 0,     1, 0, 1, 0, 0, 32'h0);
        tbl[1]  = mk(1, 32'h51, 32'h99, 0, 1,   1, 32'h60, 32'h64, 1, 0,   1, 0, 1, 0, 1, 32'h55);
        tbl[2]  = mk(1, 32'h70, 32'h74, 0, 0,   1, 32'h74, 32'h78, 0, 0,   0, 0, 0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 32'h70, 32'h74, 0, 0,   1, 32'h74, 32'h78, 0, 0,   0, 0, 0, 0, 0, 32'h0);
        tbl[4]  = mk(1, 32'h80, 32'h90, 1, 0,   1, 32'h84, 32'h88, 0, 0,   0, 0, 1, 1, 0, 32'h0);
        tbl[5]  = mk(1, 32'h100, 32'h104, 1, 1, 0, 32'h0, 32'h0, 0, 0,     1, 1, 0, 0, 0, 32'h0);
        tbl[6]  = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[7]  = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[8]  = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[9]  = mk(1, 32'h200, 32'hA00, 1, 0, 1, 32'h204, 32'hA04, 0, 0, 0, 0, 1, 1, 0, 32'h0);
        tbl[10] = mk(1, 32'h208, 32'hA08, 0, 0, 1, 32'h20C, 32'hA0C, 1, 0, 0, 0, 1, 1, 0, 32'h0);
        tbl[11] = mk(1, 32'h210, 32'hA10, 1, 0, 1, 32'h214, 32'hA14, 1, 0, 0, 1, 0, 0, 0, 32'h0);
        tbl[12] = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 1, 0, 0, 0, 32'h0);
        tbl[13] = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 1, 0, 0, 0, 32'h0);
        tbl[14] = mk(0, 32'h0, 32'h0, 0, 0,     1, 32'h300, 32'h3A0, 1, 1, 1, 0, 0, 1, 1, 32'h3A0);
        tbl[15] = mk(1, 32'h310, 32'h0, 0, 0,   0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[16] = mk(1, 32'h314, 32'h0, 0, 0,   0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[17] = mk(1, 32'h318, 32'h999, 0, 1, 0, 32'h0, 32'h0, 0, 0,     1, 0, 1, 0, 1, 32'h31C);
        tbl[18] = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[19] = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);
        tbl[20] = mk(1, 32'hFFFF_FFFE, 32'h123, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 0, 1, 32'h2);
        tbl[21] = mk(0, 32'h0, 32'h0, 0, 0,     0, 32'h0, 32'h0, 0, 0,     1, 0, 0, 0, 0, 32'h0);

        do_reset("init_reset");
        for (int i = 0; i < 2; i++) apply(pre[i], $sformatf("pre%0d", i));
        do_reset("mid_drain_reset");

        for (int i = 0; i < 22; i++) apply(tbl[i], $sformatf("v%0d", i));

        // Empty queue keeps showing the last retired entry.
        @(negedge clk);
        drive_idle();
        #1;
        chk("hold upd_valid", 32'(upd_valid), 32'd0);
        chk("hold upd_pc", upd_pc, 32'hFFFF_FFFE);
        chk("hold upd_target", upd_target, 32'h123);
        chk("hold upd_taken", 32'(upd_taken), 32'd0);

`ifdef BPARB_STATS_EN
        chk("stat_upd", 32'(stat_upd), 32'(exp_upd));
        chk("stat_mis", 32'(stat_mis), 32'(exp_mis));
`else
        chk("stat_upd", 32'(stat_upd), 32'd0);
        chk("stat_mis", 32'(stat_mis), 32'd0);
`endif

        // DEPTH=8 instance: hold count at 3 with enqueue+dequeue per cycle across wrap.
        do_reset("wrap_reset");
        @(negedge clk);
        res0_valid = 1; res0_pc = 32'h400; res0_target = 32'h800; res0_taken = 0;
        res1_valid = 1; res1_pc = 32'h404; res1_target = 32'h804; res1_taken = 1;
        upd_ready = 0;
        #1;
        chk("wrap fill0 stall", 32'(stall8), 32'd0);
        sb8.push_back('{pc: 32'h400, tg: 32'h800, tk: 1'b0});
        sb8.push_back('{pc: 32'h404, tg: 32'h804, tk: 1'b1});
        @(negedge clk);
        res1_valid = 0;
        res0_pc = 32'h408; res0_target = 32'h808; res0_taken = 1;
        #1;
        chk("wrap fill1 stall", 32'(stall8), 32'd0);
        sb8.push_back('{pc: 32'h408, tg: 32'h808, tk: 1'b1});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            res0_valid = 1;
            res0_pc = 32'h40C + 32'(4 * k);
            res0_target = 32'hC00 + 32'(k);
            res0_taken = k[0];
            upd_ready = 1;
            #1;
            chk($sformatf("wrap%0d stall", k), 32'(stall8), 32'd0);
            chk($sformatf("wrap%0d upd_valid", k), 32'(upd_valid8), 32'd1);
            e = sb8.pop_front();
            chk($sformatf("wrap%0d upd_pc", k), upd_pc8, e.pc);
            chk($sformatf("wrap%0d upd_target", k), upd_target8, e.tg);
            chk($sformatf("wrap%0d upd_taken", k), 32'(upd_taken8), 32'(e.tk));
            sb8.push_back('{pc: res0_pc, tg: res0_target, tk: res0_taken});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_idle();
            upd_ready = 1;
            #1;
            chk($sformatf("drain%0d upd_valid", i), 32'(upd_valid8), 32'd1);
            e = sb8.pop_front();
            chk($sformatf("drain%0d upd_pc", i), upd_pc8, e.pc);
            chk($sformatf("drain%0d upd_target", i), upd_target8, e.tg);
        end
        @(negedge clk);
        #1;
        chk("drain empty upd_valid", 32'(upd_valid8), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
